// File: rtl/vec_dot_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : vec_dot_feeder_if
//  Description : Bundles the operand stream, the packed-vector dot engine link
//                and the result handshake of the dot-product feeder.
//                master = feeder side, slave = environment/engine side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vec_dot_feeder_if #(
   parameter int N_ELEM = 16,
   parameter int ELEM_W = 16
);
   localparam int VEC_W = N_ELEM * ELEM_W;

   // operand pair stream
   logic              elem_valid;
   logic              elem_ready;
   logic [ELEM_W-1:0] elem_a;
   logic [ELEM_W-1:0] elem_b;
   logic              elem_last;

   // dot engine link
   logic [VEC_W-1:0]  vec_a;
   logic [VEC_W-1:0]  vec_b;
   logic              dot_rst;
   logic [ELEM_W-1:0] dot_out;
   logic              dot_finish;

   // result handshake and status
   logic              res_valid;
   logic              res_ready;
   logic [ELEM_W-1:0] res_data;
   logic              res_timeout;
   logic              busy;

   modport master (
      input  elem_valid, elem_a, elem_b, elem_last, dot_out, dot_finish, res_ready,
      output elem_ready, vec_a, vec_b, dot_rst, res_valid, res_data, res_timeout, busy
   );

   modport slave (
      output elem_valid, elem_a, elem_b, elem_last, dot_out, dot_finish, res_ready,
      input  elem_ready, vec_a, vec_b, dot_rst, res_valid, res_data, res_timeout, busy
   );
endinterface
`default_nettype wire

// File: rtl/vec_dot_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : vec_dot_feeder
//  Description : Packs up to N_ELEM signed operand pairs into vec_a/vec_b,
//                sequences the dot engine (reset release, wait for finish,
//                watchdog) and hands the result out over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_dot_feeder #(
   parameter int N_ELEM  = 16,
   parameter int ELEM_W  = 16,
   parameter int TIMEOUT = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   vec_dot_feeder_if.master       bus
);

   localparam int VEC_W  = N_ELEM * ELEM_W;
   localparam int IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
   localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_ELEM - 1);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_FILL   = 2'd0,
      S_CLEAR  = 2'd1,
      S_RUN    = 2'd2,
      S_RESULT = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [VEC_W-1:0]  vec_a_q, vec_a_d;
   logic [VEC_W-1:0]  vec_b_q, vec_b_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic [ELEM_W-1:0] res_data_q, res_data_d;
   logic              res_timeout_q, res_timeout_d;

   // State and datapath registers; reset abandons any vector or pending result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_FILL;
         idx_q         <= '0;
         vec_a_q       <= '0;
         vec_b_q       <= '0;
         wdog_q        <= '0;
         res_data_q    <= '0;
         res_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         vec_a_q       <= vec_a_d;
         vec_b_q       <= vec_b_d;
         wdog_q        <= wdog_d;
         res_data_q    <= res_data_d;
         res_timeout_q <= res_timeout_d;
      end
   end

   // Next-state logic: pack pairs, one clear cycle, run with watchdog, hold result.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      vec_a_d       = vec_a_q;
      vec_b_d       = vec_b_q;
      wdog_d        = wdog_q;
      res_data_d    = res_data_q;
      res_timeout_d = res_timeout_q;

      case (state_q)
         S_FILL: begin
            if (bus.elem_valid) begin
               for (int k = 0; k < N_ELEM; k++) begin
                  if (idx_q == IDX_W'(k)) begin
                     vec_a_d[k*ELEM_W +: ELEM_W] = bus.elem_a;
                     vec_b_d[k*ELEM_W +: ELEM_W] = bus.elem_b;
                  end
               end
               idx_d = idx_q + 1'b1;
               if ((idx_q == IDX_LAST) || bus.elem_last) begin
                  state_d = S_CLEAR;
               end
            end
         end

         S_CLEAR: begin
            state_d = S_RUN;
         end

         S_RUN: begin
            // The counter may wrap on the exit cycle; it is cleared before reuse.
            wdog_d = wdog_q + 1'b1;
            if (bus.dot_finish) begin
               res_data_d    = bus.dot_out;
               res_timeout_d = 1'b0;
               state_d       = S_RESULT;
            end else if (wdog_q == WDOG_LAST) begin
               res_data_d    = '0;
               res_timeout_d = 1'b1;
               state_d       = S_RESULT;
            end
         end

         S_RESULT: begin
            if (bus.res_ready) begin
               vec_a_d = '0;
               vec_b_d = '0;
               idx_d   = '0;
               wdog_d  = '0;
               state_d = S_FILL;
            end
         end

         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   // Status outputs are pure state decodes so an async reset shows up at once.
   assign bus.elem_ready  = (state_q == S_FILL);
   assign bus.busy        = (state_q != S_FILL);
   assign bus.dot_rst     = (state_q != S_RUN);
   assign bus.res_valid   = (state_q == S_RESULT);
   assign bus.vec_a       = vec_a_q;
   assign bus.vec_b       = vec_b_q;
   assign bus.res_data    = res_data_q;
   assign bus.res_timeout = res_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_vec_dot_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_dot_feeder
//  Description : Scoreboard bench for vec_dot_feeder with a behavioural dot
//                engine whose finish delay is programmable per vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_dot_feeder;

   localparam int N_ELEM  = 16;
   localparam int ELEM_W  = 16;
   localparam int TIMEOUT = 32;
   localparam int VEC_W   = N_ELEM * ELEM_W;
   localparam int NEVER   = 100000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   vec_dot_feeder_if #(.N_ELEM(N_ELEM), .ELEM_W(ELEM_W)) bus ();

   vec_dot_feeder #(.N_ELEM(N_ELEM), .ELEM_W(ELEM_W), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] data;
      logic        timeout;
      int          t_last;
      int          lat;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] sa[$];
   logic [15:0] sb[$];
   int          rr_mode = 0;   // 0: res_ready low, 1: high, 2: random

   task automatic chk(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Q4.11 product sum rescaled to Q4.11 and truncated to 16 bits
   function automatic logic [15:0] q_sum(input longint s);
      longint r;
      r = s >>> 11;
      return r[15:0];
   endfunction

   function automatic logic [15:0] eng_dot(input logic [VEC_W-1:0] va, input logic [VEC_W-1:0] vb);
      longint s = 0;
      for (int k = 0; k < N_ELEM; k++)
         s += longint'($signed(va[k*ELEM_W +: ELEM_W])) * longint'($signed(vb[k*ELEM_W +: ELEM_W]));
      return q_sum(s);
   endfunction

   // Behavioural engine: finishes eng_delay cycles after its reset is released.
   int eng_delay = 17;
   int run_cnt   = 0;
   always @(posedge clk) run_cnt <= bus.dot_rst ? 0 : run_cnt + 1;
   assign bus.dot_finish = !bus.dot_rst && (run_cnt == eng_delay);
   assign bus.dot_out    = eng_dot(bus.vec_a, bus.vec_b);

   // res_ready driver
   initial begin
      bus.res_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rr_mode)
            0:       bus.res_ready = 1'b0;
            1:       bus.res_ready = 1'b1;
            default: bus.res_ready = ($urandom_range(0, 1) == 1);
         endcase
      end
   end

   // Monitor: hold stability while stalled, pop and compare on handshake.
   logic        seen = 1'b0;
   int          first_cyc = 0;
   logic [15:0] hd;
   logic        ht;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         seen = 1'b0;
      end else if (bus.res_valid) begin
         if (!seen) begin
            seen = 1'b1;
            first_cyc = cyc;
            hd = bus.res_data;
            ht = bus.res_timeout;
         end else begin
            chk("hold res_data", bus.res_data, hd);
            chk("hold res_timeout", bus.res_timeout, ht);
         end
         if (bus.res_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected result: got 0x%0h, required none", bus.res_data);
            end else begin
               e = exp_q.pop_front();
               chk("res_data", bus.res_data, e.data);
               chk("res_timeout", bus.res_timeout, e.timeout);
               chk("result latency", first_cyc - e.t_last, e.lat);
            end
            seen = 1'b0;
         end
      end
   end

   // Sends sa/sb as one vector; returns at the negedge of the cycle after the
   // last acceptance. Expected result: engine value unless delay >= TIMEOUT.
   task automatic send_vec(input int delay, input logic mark_last, input logic gaps, output int t_last);
      longint s = 0;
      int     w;
      exp_t   e;
      w = 0;
      while (!bus.elem_ready && w < 300) begin @(negedge clk); w++; end
      chk("elem_ready before vector", bus.elem_ready, 1'b1);
      eng_delay = delay;
      t_last = 0;
      for (int i = 0; i < sa.size(); i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            bus.elem_valid = 1'b0;
            bus.elem_last  = 1'b1;
            bus.elem_a     = 16'($urandom);
            @(negedge clk);
         end
         bus.elem_valid = 1'b1;
         bus.elem_a     = sa[i];
         bus.elem_b     = sb[i];
         bus.elem_last  = mark_last && (i == sa.size() - 1);
         w = 0;
         while (!bus.elem_ready && w < 300) begin @(negedge clk); w++; end
         chk("elem_ready during fill", bus.elem_ready, 1'b1);
         t_last = cyc;
         s += longint'($signed(sa[i])) * longint'($signed(sb[i]));
         @(negedge clk);
      end
      bus.elem_valid = 1'b0;
      bus.elem_last  = 1'b0;
      e.timeout = (delay >= TIMEOUT);
      e.data    = e.timeout ? 16'h0000 : q_sum(s);
      e.t_last  = t_last;
      e.lat     = 2 + (e.timeout ? TIMEOUT : delay + 1);
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 1000) begin @(negedge clk); w++; end
      chk("results drained", exp_q.size(), 0);
   endtask

   task automatic fill_random(input int n);
      sa.delete();
      sb.delete();
      for (int i = 0; i < n; i++) begin
         sa.push_back(16'($urandom));
         sb.push_back(16'($urandom));
      end
   endtask

   initial begin
      int t;
      int w;
      logic [VEC_W-1:0] ev;
      bus.elem_valid = 1'b0;
      bus.elem_last  = 1'b0;
      bus.elem_a     = '0;
      bus.elem_b     = '0;

      // reset state
      repeat (3) @(negedge clk);
      chk("reset elem_ready", bus.elem_ready, 1'b1);
      chk("reset dot_rst", bus.dot_rst, 1'b1);
      chk("reset res_valid", bus.res_valid, 1'b0);
      chk("reset vec_a", bus.vec_a, '0);
      chk("reset vec_b", bus.vec_b, '0);
      chk("reset res_data", bus.res_data, '0);
      chk("reset res_timeout", bus.res_timeout, 1'b0);
      chk("reset busy", bus.busy, 1'b0);
      rst_n = 1'b1;
      rr_mode = 1;
      @(negedge clk);

      // full vector, nominal engine
      sa.delete(); sb.delete();
      for (int i = 0; i < N_ELEM; i++) begin sa.push_back(16'h0800); sb.push_back(16'h0100); end
      send_vec(17, 1'b0, 1'b0, t);
      ev = {N_ELEM{16'h0800}};
      chk("full vec_a", bus.vec_a, ev);
      ev = {N_ELEM{16'h0100}};
      chk("full vec_b", bus.vec_b, ev);
      drain();

      // short vector closed by elem_last, zero padded
      sa.delete(); sb.delete();
      for (int i = 0; i < 3; i++) begin sa.push_back(16'h0800); sb.push_back(16'h0800); end
      send_vec(17, 1'b1, 1'b0, t);
      chk("clear busy", bus.busy, 1'b1);
      chk("clear dot_rst", bus.dot_rst, 1'b1);
      chk("clear elem_ready", bus.elem_ready, 1'b0);
      ev = '0;
      ev[47:0] = {3{16'h0800}};
      chk("short vec_a", bus.vec_a, ev);
      @(negedge clk);
      chk("run dot_rst", bus.dot_rst, 1'b0);
      drain();

      // engine never finishes: watchdog result
      fill_random(5);
      send_vec(NEVER, 1'b1, 1'b0, t);
      drain();

      // finish on the last watchdog cycle wins
      fill_random(N_ELEM);
      send_vec(TIMEOUT - 1, 1'b0, 1'b0, t);
      drain();

      // stalled result, elem_valid ignored outside FILL
      rr_mode = 0;
      fill_random(N_ELEM);
      send_vec(17, 1'b0, 1'b0, t);
      w = 0;
      while (!bus.res_valid && w < 100) begin @(negedge clk); w++; end
      chk("stall res_valid seen", bus.res_valid, 1'b1);
      for (int i = 0; i < 10; i++) begin
         bus.elem_valid = 1'b1;
         bus.elem_last  = 1'b1;
         bus.elem_a     = 16'($urandom);
         @(negedge clk);
         chk("stall res_valid", bus.res_valid, 1'b1);
         chk("stall elem_ready", bus.elem_ready, 1'b0);
      end
      bus.elem_valid = 1'b0;
      bus.elem_last  = 1'b0;
      rr_mode = 1;
      @(negedge clk);
      rr_mode = 0;
      @(negedge clk);
      chk("after take elem_ready", bus.elem_ready, 1'b1);
      chk("after take res_valid", bus.res_valid, 1'b0);
      chk("after take vec_a", bus.vec_a, '0);
      chk("after take queue", exp_q.size(), 0);

      // asynchronous reset in the middle of RUN
      rr_mode = 1;
      fill_random(N_ELEM);
      send_vec(NEVER, 1'b0, 1'b0, t);
      w = 0;
      while (bus.dot_rst && w < 20) begin @(negedge clk); w++; end
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst dot_rst", bus.dot_rst, 1'b1);
      chk("async rst res_valid", bus.res_valid, 1'b0);
      chk("async rst vec_a", bus.vec_a, '0);
      chk("async rst elem_ready", bus.elem_ready, 1'b1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post rst elem_ready", bus.elem_ready, 1'b1);
      chk("post rst busy", bus.busy, 1'b0);

      // randomized vectors, lengths, engine delays and back-pressure
      rr_mode = 2;
      for (int v = 0; v < 30; v++) begin
         int n;
         int d;
         logic ml;
         n = $urandom_range(1, N_ELEM);
         case ($urandom_range(0, 4))
            0:       d = $urandom_range(0, 40);
            1:       d = TIMEOUT - 1;
            2:       d = TIMEOUT;
            default: d = 17;
         endcase
         ml = (n < N_ELEM) ? 1'b1 : ($urandom_range(0, 1) == 1);
         fill_random(n);
         send_vec(d, ml, 1'b1, t);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL global timeout: got %0d cycles, required completion", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
